// File: rtl/axis_strip_pkg.sv
// Shared types and stream port macros for the header-strip block.
// Optional statistics are enabled with AXIS_HEADER_STRIP_STATS_EN.

`ifndef AXIS_I_SLAVE_PORTS
`define AXIS_I_SLAVE_PORTS \
  output logic                    axis_i_tready, \
  input  logic                    axis_i_tvalid, \
  input  logic                    axis_i_tlast, \
  input  logic [AXIS_BYTES-1:0]   axis_i_tkeep, \
  input  logic [8*AXIS_BYTES-1:0] axis_i_tdata
`endif

`ifndef AXIS_O_MASTER_PORTS
`define AXIS_O_MASTER_PORTS \
  input  logic                    axis_o_tready, \
  output logic                    axis_o_tvalid, \
  output logic                    axis_o_tlast, \
  output logic [AXIS_BYTES-1:0]   axis_o_tkeep, \
  output logic [8*AXIS_BYTES-1:0] axis_o_tdata
`endif

package axis_strip_pkg;

  typedef enum logic [1:0] {
    ST_FIRST = 2'd0,
    ST_STRIP = 2'd1,
    ST_PASS  = 2'd2
  } strip_state_e;

  localparam int unsigned COUNT_W_DEFAULT = 16;

endpackage

// File: rtl/axis_keep_mask.sv
// Per-beat keep mask: clears the lowest set tkeep lanes while header bytes
// remain, and reports how many lanes were cleared.

module axis_keep_mask #(
    parameter int unsigned AXIS_BYTES = 4,
    parameter int unsigned COUNT_W    = 16
) (
    input  logic [AXIS_BYTES-1:0] tkeep,
    input  logic [COUNT_W-1:0]    remaining,
    output logic [AXIS_BYTES-1:0] masked_keep,
    output logic [COUNT_W-1:0]    stripped
);

    // Walk lanes from 0 upward, consuming valid bytes until remaining is used up.
    always_comb begin
        masked_keep = tkeep;
        stripped    = '0;
        for (int unsigned i = 0; i < AXIS_BYTES; i++) begin
            if (tkeep[i] && (stripped < remaining)) begin
                masked_keep[i] = 1'b0;
                stripped       = stripped + COUNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/axis_header_strip.sv
// AXI-Stream header stripper: removes the first strip_bytes valid bytes of
// each packet by clearing tkeep, drops beats left with no bytes, and
// registers the output stage (one cycle latency).
// Define AXIS_HEADER_STRIP_STATS_EN to add the dropped_pkts counter port.

module axis_header_strip
  import axis_strip_pkg::*;
#(
  parameter int unsigned AXIS_BYTES = 4,
  parameter int unsigned COUNT_W    = COUNT_W_DEFAULT
) (
  input  logic               clk,
  input  logic               aresetn,
  input  logic [COUNT_W-1:0] strip_bytes,
  `AXIS_I_SLAVE_PORTS,
  `AXIS_O_MASTER_PORTS
`ifdef AXIS_HEADER_STRIP_STATS_EN
  ,
  output logic [31:0]        dropped_pkts
`endif
);

  strip_state_e              state_q, state_d;
  logic [COUNT_W-1:0]        remaining_q, remaining_d;
  logic                      emitted_q, emitted_d;
  logic                      o_valid_q, o_valid_d;
  logic                      o_last_q, o_last_d;
  logic [AXIS_BYTES-1:0]     o_keep_q, o_keep_d;
  logic [8*AXIS_BYTES-1:0]   o_data_q, o_data_d;

  logic [COUNT_W-1:0]        rem_eff;
  logic [COUNT_W-1:0]        stripped;
  logic [AXIS_BYTES-1:0]     masked_keep;
  logic                      in_fire;
  logic                      keep_beat;

  assign axis_i_tready = aresetn && (!o_valid_q || axis_o_tready);
  assign in_fire       = axis_i_tvalid && axis_i_tready;

  assign axis_o_tvalid = o_valid_q;
  assign axis_o_tlast  = o_last_q;
  assign axis_o_tkeep  = o_keep_q;
  assign axis_o_tdata  = o_data_q;

  axis_keep_mask #(
    .AXIS_BYTES (AXIS_BYTES),
    .COUNT_W    (COUNT_W)
  ) u_mask (
    .tkeep       (axis_i_tkeep),
    .remaining   (rem_eff),
    .masked_keep (masked_keep),
    .stripped    (stripped)
  );

  // Next state, strip budget and output stage. A beat survives if it still
  // carries bytes, or if it is a null tlast closing a packet that already
  // emitted something; a fully stripped packet emits nothing at all.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    emitted_d   = emitted_q;
    o_valid_d   = o_valid_q;
    o_last_d    = o_last_q;
    o_keep_d    = o_keep_q;
    o_data_d    = o_data_q;

    rem_eff   = (state_q == ST_FIRST) ? strip_bytes : remaining_q;
    keep_beat = (masked_keep != '0) ||
                (axis_i_tlast && (state_q != ST_FIRST) && emitted_q);

    if (in_fire) begin
      if (axis_i_tlast) begin
        state_d     = ST_FIRST;
        remaining_d = '0;
        emitted_d   = 1'b0;
      end else begin
        remaining_d = rem_eff - stripped;
        state_d     = (remaining_d != '0) ? ST_STRIP : ST_PASS;
        emitted_d   = ((state_q != ST_FIRST) && emitted_q) || keep_beat;
      end
    end

    if (in_fire && keep_beat) begin
      o_valid_d = 1'b1;
      o_last_d  = axis_i_tlast;
      o_keep_d  = masked_keep;
      o_data_d  = axis_i_tdata;
    end else if (axis_o_tready) begin
      o_valid_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_FIRST;
      remaining_q <= '0;
      emitted_q   <= 1'b0;
      o_valid_q   <= 1'b0;
      o_last_q    <= 1'b0;
      o_keep_q    <= '0;
      o_data_q    <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      emitted_q   <= emitted_d;
      o_valid_q   <= o_valid_d;
      o_last_q    <= o_last_d;
      o_keep_q    <= o_keep_d;
      o_data_q    <= o_data_d;
    end
  end

`ifdef AXIS_HEADER_STRIP_STATS_EN
  logic        drop_pkt;
  logic [31:0] dropped_q, dropped_d;

  assign drop_pkt     = in_fire && axis_i_tlast && !keep_beat;
  assign dropped_pkts = dropped_q;

  // Saturating count of packets that were stripped away entirely.
  always_comb begin
    dropped_d = dropped_q;
    if (drop_pkt && (dropped_q != '1)) begin
      dropped_d = dropped_q + 32'd1;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      dropped_q <= '0;
    end else begin
      dropped_q <= dropped_d;
    end
  end
`endif

endmodule

// File: tb/tb_axis_header_strip.sv
// Self-checking bench for axis_header_strip (AXIS_BYTES=4): directed cases
// followed by randomized packets against a byte-counting reference model.

module tb_axis_header_strip;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic [15:0] strip_bytes = '0;
    logic        axis_i_tready;
    logic        axis_i_tvalid = 1'b0;
    logic        axis_i_tlast = 1'b0;
    logic [3:0]  axis_i_tkeep = '0;
    logic [31:0] axis_i_tdata = '0;
    logic        axis_o_tready = 1'b0;
    logic        axis_o_tvalid;
    logic        axis_o_tlast;
    logic [3:0]  axis_o_tkeep;
    logic [31:0] axis_o_tdata;
`ifdef AXIS_HEADER_STRIP_STATS_EN
    logic [31:0] dropped_pkts;
`endif

    axis_header_strip #(
        .AXIS_BYTES (4),
        .COUNT_W    (16)
    ) dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .strip_bytes   (strip_bytes),
        .axis_i_tready (axis_i_tready),
        .axis_i_tvalid (axis_i_tvalid),
        .axis_i_tlast  (axis_i_tlast),
        .axis_i_tkeep  (axis_i_tkeep),
        .axis_i_tdata  (axis_i_tdata),
        .axis_o_tready (axis_o_tready),
        .axis_o_tvalid (axis_o_tvalid),
        .axis_o_tlast  (axis_o_tlast),
        .axis_o_tkeep  (axis_o_tkeep),
        .axis_o_tdata  (axis_o_tdata)
`ifdef AXIS_HEADER_STRIP_STATS_EN
        ,
        .dropped_pkts  (dropped_pkts)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  keep;
        logic [31:0] data;
        logic        last;
        logic [15:0] strip;
    } beat_t;

    typedef struct {
        logic [3:0]  keep;
        logic [31:0] data;
        logic        last;
    } obeat_t;

    beat_t  tx_q[$];
    obeat_t exp_q[$];
    obeat_t log_q[$];

    int checks = 0;
    int failures = 0;

    // Reference model state: packet-level byte counting.
    bit          m_first = 1'b1;
    int unsigned m_strip = 0;
    int unsigned m_idx = 0;
    bit          m_emit = 1'b0;
    int unsigned m_drops = 0;

    // Stimulus / observation control.
    bit          rdy_mode = 1'b1;
    bit          vld_mode = 1'b1;
    bit          force_rdy = 1'b0;
    int unsigned stall_cnt = 0;
    bit          prev_stall = 1'b0;
    obeat_t      snap;
    bit          lat_pending = 1'b0;
    obeat_t      lat_exp;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] seq_word(input int unsigned k);
        logic [7:0] b0, b1, b2, b3;
        b0 = 8'(4 * k);
        b1 = 8'(4 * k + 1);
        b2 = 8'(4 * k + 2);
        b3 = 8'(4 * k + 3);
        return {b3, b2, b1, b0};
    endfunction

    task automatic add_beat(input logic [3:0] keep, input logic [31:0] data,
                            input logic last, input logic [15:0] strip);
        beat_t b;
        b.keep = keep; b.data = data; b.last = last; b.strip = strip;
        tx_q.push_back(b);
    endtask

    task automatic model_reset();
        m_first = 1'b1; m_strip = 0; m_idx = 0; m_emit = 1'b0; m_drops = 0;
    endtask

    // The k-th valid byte of a packet is removed when k < strip count.
    task automatic model_accept(input beat_t b);
        obeat_t o;
        if (m_first) begin
            m_strip = b.strip; m_idx = 0; m_emit = 1'b0; m_first = 1'b0;
        end
        o.keep = b.keep; o.data = b.data; o.last = b.last;
        for (int i = 0; i < 4; i++) begin
            if (b.keep[i]) begin
                if (m_idx < m_strip) o.keep[i] = 1'b0;
                m_idx++;
            end
        end
        if (o.keep != 4'h0 || (b.last && m_emit)) begin
            exp_q.push_back(o);
            m_emit = 1'b1;
        end else if (b.last) begin
            m_drops++;
        end
        if (b.last) m_first = 1'b1;
    endtask

    task automatic step();
        beat_t       b;
        obeat_t      o;
        int unsigned n_before;
        @(negedge clk);
        if (force_rdy) axis_o_tready = 1'b1;
        else if (stall_cnt > 0) begin axis_o_tready = 1'b0; stall_cnt--; end
        else if (rdy_mode) axis_o_tready = 1'b1;
        else axis_o_tready = ($urandom_range(9) < 7);
        if (tx_q.size() > 0 && (vld_mode || $urandom_range(9) < 8)) begin
            b = tx_q[0];
            axis_i_tvalid = 1'b1; axis_i_tkeep = b.keep; axis_i_tdata = b.data;
            axis_i_tlast = b.last; strip_bytes = b.strip;
        end else begin
            axis_i_tvalid = 1'b0; axis_i_tkeep = 4'($urandom); axis_i_tdata = $urandom;
            axis_i_tlast = 1'($urandom); strip_bytes = 16'($urandom);
        end
        #1;
        if (prev_stall) begin
            check_eq("stable_valid", axis_o_tvalid, 1'b1);
            check_eq("stable_keep", axis_o_tkeep, snap.keep);
            check_eq("stable_data", axis_o_tdata, snap.data);
            check_eq("stable_last", axis_o_tlast, snap.last);
        end
        if (lat_pending) begin
            check_eq("lat_valid", axis_o_tvalid, 1'b1);
            check_eq("lat_keep", axis_o_tkeep, lat_exp.keep);
            check_eq("lat_data", axis_o_tdata, lat_exp.data);
            lat_pending = 1'b0;
        end
        if (axis_o_tvalid && axis_o_tready) begin
            check_eq("out_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                o = exp_q.pop_front();
                check_eq("out_keep", axis_o_tkeep, o.keep);
                check_eq("out_data", axis_o_tdata, o.data);
                check_eq("out_last", axis_o_tlast, o.last);
            end
            o.keep = axis_o_tkeep; o.data = axis_o_tdata; o.last = axis_o_tlast;
            log_q.push_back(o);
        end
        prev_stall = axis_o_tvalid && !axis_o_tready;
        snap.keep = axis_o_tkeep; snap.data = axis_o_tdata; snap.last = axis_o_tlast;
        if (axis_i_tvalid && axis_i_tready) begin
            b = tx_q.pop_front();
            n_before = exp_q.size();
            model_accept(b);
            if (exp_q.size() > n_before) begin
                lat_pending = 1'b1;
                lat_exp = exp_q[$];
            end
        end
    endtask

    task automatic run_pkts(input int unsigned max_cycles);
        int unsigned n;
        n = 0;
        while (tx_q.size() > 0 && n < max_cycles) begin step(); n++; end
        check_eq("tx_timeout", tx_q.size(), 0);
        tx_q.delete();
        force_rdy = 1'b1;
        n = 0;
        while (exp_q.size() > 0 && n < 100) begin step(); n++; end
        check_eq("drain_left", exp_q.size(), 0);
        exp_q.delete();
        step();
        check_eq("idle_valid", axis_o_tvalid, 1'b0);
        force_rdy = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        aresetn = 1'b0;
        axis_i_tvalid = 1'b0;
        #1;
        check_eq("rst_valid", axis_o_tvalid, 1'b0);
        check_eq("rst_last", axis_o_tlast, 1'b0);
        check_eq("rst_keep", axis_o_tkeep, 4'h0);
        check_eq("rst_data", axis_o_tdata, 32'h0);
        check_eq("rst_tready", axis_i_tready, 1'b0);
        repeat (2) @(negedge clk);
        axis_o_tready = 1'b1;
        #1;
        check_eq("rst_tready_hold", axis_i_tready, 1'b0);
`ifdef AXIS_HEADER_STRIP_STATS_EN
        check_eq("rst_dropped", dropped_pkts, 32'h0);
`endif
        aresetn = 1'b1;
        model_reset();
        tx_q.delete(); exp_q.delete();
        lat_pending = 1'b0; prev_stall = 1'b0;
    endtask

    initial begin
        do_reset();

        // Pass-through: strip 0, two full beats.
        log_q.delete();
        add_beat(4'hF, seq_word(0), 1'b0, 16'd0);
        add_beat(4'hF, seq_word(1), 1'b1, 16'd9);
        run_pkts(50);
        check_eq("t031_count", log_q.size(), 2);
        if (log_q.size() == 2) begin
            check_eq("t031_data1", log_q[1].data, seq_word(1));
            check_eq("t031_last1", log_q[1].last, 1'b1);
        end

        // Strip 6 over three beats of bytes 0..11.
        log_q.delete();
        add_beat(4'hF, seq_word(0), 1'b0, 16'd6);
        add_beat(4'hF, seq_word(1), 1'b0, 16'd0);
        add_beat(4'hF, seq_word(2), 1'b1, 16'd0);
        run_pkts(50);
        check_eq("t032_count", log_q.size(), 2);
        if (log_q.size() == 2) begin
            check_eq("t032_keep0", log_q[0].keep, 4'b1100);
            check_eq("t032_hi0", log_q[0].data[31:16], 16'h0706);
            check_eq("t032_keep1", log_q[1].keep, 4'b1111);
            check_eq("t032_last1", log_q[1].last, 1'b1);
        end

        // Strip 3 with a sparse first beat.
        log_q.delete();
        add_beat(4'b1011, 32'hA3A2A1A0, 1'b0, 16'd3);
        add_beat(4'b1111, 32'hB3B2B1B0, 1'b1, 16'd0);
        run_pkts(50);
        check_eq("t033_count", log_q.size(), 1);
        if (log_q.size() == 1) begin
            check_eq("t033_keep", log_q[0].keep, 4'b1111);
            check_eq("t033_last", log_q[0].last, 1'b1);
        end

        // Whole packet stripped, then an intact packet.
        log_q.delete();
        add_beat(4'hF, 32'h11111111, 1'b0, 16'd8);
        add_beat(4'hF, 32'h22222222, 1'b1, 16'd0);
        run_pkts(50);
        check_eq("t034_none", log_q.size(), 0);
`ifdef AXIS_HEADER_STRIP_STATS_EN
        check_eq("t034_dropped", dropped_pkts, 32'd1);
`endif
        add_beat(4'hF, 32'h33333333, 1'b1, 16'd0);
        run_pkts(50);
        check_eq("t034_next", log_q.size(), 1);

        // Output back-pressure for five cycles.
        add_beat(4'hF, seq_word(0), 1'b0, 16'd0);
        add_beat(4'hF, seq_word(1), 1'b0, 16'd0);
        add_beat(4'hF, seq_word(2), 1'b1, 16'd0);
        step();
        stall_cnt = 5;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("t035_tready", axis_i_tready, 1'b0);
            check_eq("t035_valid", axis_o_tvalid, 1'b1);
        end
        run_pkts(50);

        // Reset in the middle of a stripped packet.
        add_beat(4'hF, seq_word(0), 1'b0, 16'd6);
        run_pkts(50);
        do_reset();
        log_q.delete();
        add_beat(4'hF, 32'hDDCCBBAA, 1'b1, 16'd2);
        run_pkts(50);
        check_eq("t036_count", log_q.size(), 1);
        if (log_q.size() == 1) check_eq("t036_keep", log_q[0].keep, 4'b1100);

        // Randomized packets with random valid/ready.
        rdy_mode = 1'b0;
        vld_mode = 1'b0;
        for (int p = 0; p < 60; p++) begin
            int unsigned nb;
            logic [15:0] st;
            nb = $urandom_range(1, 5);
            st = 16'($urandom_range(0, 20));
            for (int k = 0; k < int'(nb); k++) begin
                logic [3:0] kp;
                kp = ($urandom_range(9) < 2) ? 4'h0 : 4'($urandom);
                add_beat(kp, $urandom, (k == int'(nb) - 1),
                         (k == 0) ? st : 16'($urandom));
            end
        end
        run_pkts(5000);
`ifdef AXIS_HEADER_STRIP_STATS_EN
        check_eq("rand_dropped", dropped_pkts, 32'(m_drops));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
